// File: rtl/execute_unit_if.sv
// execute_unit_if: request/response bundle between the controller and the
// execute unit.
//   request  : op_valid, op, operand_a, operand_b, carry_in
//   response : busy, result_valid, result_lo, result_hi,
//              flag_c, flag_z, flag_n, flag_v, div_zero
// master = controller side, slave = execute unit side.
interface execute_unit_if #(
   parameter int WIDTH = 32
);
   logic             op_valid;
   logic [4:0]       op;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             carry_in;
   logic             busy;
   logic             result_valid;
   logic [WIDTH-1:0] result_lo;
   logic [WIDTH-1:0] result_hi;
   logic             flag_c;
   logic             flag_z;
   logic             flag_n;
   logic             flag_v;
   logic             div_zero;

   modport master (
      output op_valid, op, operand_a, operand_b, carry_in,
      input  busy, result_valid, result_lo, result_hi,
             flag_c, flag_z, flag_n, flag_v, div_zero
   );

   modport slave (
      input  op_valid, op, operand_a, operand_b, carry_in,
      output busy, result_valid, result_lo, result_hi,
             flag_c, flag_z, flag_n, flag_v, div_zero
   );
endinterface

// File: rtl/execute_unit.sv
// execute_unit: ALU back end of the execute path. Single-cycle ops return a
// registered result one cycle after acceptance; multiply (shift-add) and
// divide (restoring) iterate one bit per cycle with busy raised.
//   clk, reset : clock, synchronous active-high reset
//   bus        : execute_unit_if.slave (op request in, result/flags out)
//
// state  | meaning
// S_IDLE | accept a new op; single-cycle results and divide-by-zero land here
// S_ITER | one multiply/divide bit per cycle, cnt_q counts WIDTH-1 down to 0
// S_FIX  | sign correction and result/flag registration
module execute_unit #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input logic         clk,
   input logic         reset,
   execute_unit_if.slave bus
);
   localparam logic [4:0] OP_ADD = 5'd1,  OP_ADC = 5'd2,  OP_SUB = 5'd3,  OP_SBB = 5'd4;
   localparam logic [4:0] OP_AND = 5'd5,  OP_OR  = 5'd6,  OP_XOR = 5'd7,  OP_NOT = 5'd8;
   localparam logic [4:0] OP_SHL = 5'd9,  OP_SHR = 5'd10, OP_SAR = 5'd11, OP_ROL = 5'd12;
   localparam logic [4:0] OP_ROR = 5'd13, OP_RCL = 5'd14, OP_RCR = 5'd15;
   localparam logic [4:0] OP_UMUL = 5'd16, OP_SMUL = 5'd17, OP_UDIV = 5'd18, OP_SDIV = 5'd19;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
   logic             is_div_q, is_div_d, is_signed_q, is_signed_d;
   logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, ovf_q, ovf_d;
   logic             result_valid_q, result_valid_d;
   logic [WIDTH-1:0] result_lo_q, result_lo_d, result_hi_q, result_hi_d;
   logic             flag_c_q, flag_c_d, flag_z_q, flag_z_d;
   logic             flag_n_q, flag_n_d, flag_v_q, flag_v_d;
   logic             div_zero_q, div_zero_d;

   logic [WIDTH-1:0]   a, b, sc_lo, mag_a, mag_b, quo, rem, ext;
   logic               sc_c, sc_v, cin_use, signed_op, sign_a, sign_b;
   logic [SHW-1:0]     amt;
   logic [SHW:0]       amt_ext, rot_inv, rcx_inv;
   logic [WIDTH:0]     add_ext, shx, rcx, mul_sum, div_try;
   logic signed [WIDTH:0] sar_src;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      acc_hi_d       = acc_hi_q;
      acc_lo_d       = acc_lo_q;
      opnd_d         = opnd_q;
      is_div_d       = is_div_q;
      is_signed_d    = is_signed_q;
      neg_res_d      = neg_res_q;
      neg_rem_d      = neg_rem_q;
      ovf_d          = ovf_q;
      result_valid_d = 1'b0;
      result_lo_d    = result_lo_q;
      result_hi_d    = result_hi_q;
      flag_c_d       = flag_c_q;
      flag_z_d       = flag_z_q;
      flag_n_d       = flag_n_q;
      flag_v_d       = flag_v_q;
      div_zero_d     = div_zero_q;

      a       = bus.operand_a;
      b       = bus.operand_b;
      amt     = b[SHW-1:0];
      amt_ext = {1'b0, amt};
      rot_inv = (SHW+1)'(WIDTH) - amt_ext;
      rcx_inv = (SHW+1)'(WIDTH+1) - amt_ext;
      sc_lo   = '0;
      sc_c    = 1'b0;
      sc_v    = 1'b0;
      shx     = '0;
      rcx     = '0;
      sar_src = {a, 1'b0};
      cin_use = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) && bus.carry_in;
      add_ext = '0;

      case (bus.op)
         OP_ADD, OP_ADC: begin
            add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_use};
            sc_lo   = add_ext[WIDTH-1:0];
            sc_c    = add_ext[WIDTH];
            sc_v    = (a[WIDTH-1] == b[WIDTH-1]) && (sc_lo[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB, OP_SBB: begin
            add_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_use};
            sc_lo   = add_ext[WIDTH-1:0];
            sc_c    = add_ext[WIDTH];
            sc_v    = (a[WIDTH-1] != b[WIDTH-1]) && (sc_lo[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: sc_lo = a & b;
         OP_OR:  sc_lo = a | b;
         OP_XOR: sc_lo = a ^ b;
         OP_NOT: sc_lo = ~a;
         // The spare bit of shx catches the last bit shifted out.
         OP_SHL: begin
            shx   = {1'b0, a} << amt;
            sc_lo = shx[WIDTH-1:0];
            sc_c  = shx[WIDTH];
         end
         OP_SHR: begin
            shx   = {a, 1'b0} >> amt;
            sc_lo = shx[WIDTH:1];
            sc_c  = shx[0];
         end
         OP_SAR: begin
            shx   = sar_src >>> amt;
            sc_lo = shx[WIDTH:1];
            sc_c  = shx[0];
         end
         OP_ROL: begin
            sc_lo = (a << amt) | (a >> rot_inv);
            sc_c  = sc_lo[0];
         end
         OP_ROR: begin
            sc_lo = (a >> amt) | (a << rot_inv);
            sc_c  = sc_lo[WIDTH-1];
         end
         OP_RCL: begin
            rcx   = ({bus.carry_in, a} << amt) | ({bus.carry_in, a} >> rcx_inv);
            sc_lo = rcx[WIDTH-1:0];
            sc_c  = rcx[WIDTH];
         end
         OP_RCR: begin
            rcx   = ({bus.carry_in, a} >> amt) | ({bus.carry_in, a} << rcx_inv);
            sc_lo = rcx[WIDTH-1:0];
            sc_c  = rcx[WIDTH];
         end
         default: ;
      endcase

      if ((bus.op >= OP_SHL) && (bus.op <= OP_RCR) && (amt == '0)) begin
         sc_lo = a;
         sc_c  = bus.carry_in;
      end

      // Signed mul/div work on magnitudes; signs are fixed up in S_FIX.
      signed_op = (bus.op == OP_SMUL) || (bus.op == OP_SDIV);
      sign_a    = signed_op && a[WIDTH-1];
      sign_b    = signed_op && b[WIDTH-1];
      mag_a     = sign_a ? -a : a;
      mag_b     = sign_b ? -b : b;

      mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_try = {acc_hi_q, acc_lo_q[WIDTH-1]} - {1'b0, opnd_q};
      prod    = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
      quo     = neg_res_q ? -acc_lo_q : acc_lo_q;
      rem     = neg_rem_q ? -acc_hi_q : acc_hi_q;
      ext     = is_signed_q ? {WIDTH{prod[WIDTH-1]}} : '0;

      case (state_q)
         S_IDLE: begin
            if (bus.op_valid) begin
               if ((bus.op >= OP_ADD) && (bus.op <= OP_RCR)) begin
                  result_valid_d = 1'b1;
                  result_lo_d    = sc_lo;
                  result_hi_d    = '0;
                  flag_c_d       = sc_c;
                  flag_z_d       = (sc_lo == '0);
                  flag_n_d       = sc_lo[WIDTH-1];
                  flag_v_d       = sc_v;
                  div_zero_d     = 1'b0;
               end else if ((bus.op == OP_UMUL) || (bus.op == OP_SMUL)) begin
                  acc_hi_d    = '0;
                  acc_lo_d    = mag_b;
                  opnd_d      = mag_a;
                  is_div_d    = 1'b0;
                  is_signed_d = signed_op;
                  neg_res_d   = sign_a ^ sign_b;
                  neg_rem_d   = 1'b0;
                  ovf_d       = 1'b0;
                  cnt_d       = SHW'(WIDTH-1);
                  state_d     = S_ITER;
               end else if ((bus.op == OP_UDIV) || (bus.op == OP_SDIV)) begin
                  if (b == '0) begin
                     result_valid_d = 1'b1;
                     result_lo_d    = '1;
                     result_hi_d    = a;
                     flag_c_d       = 1'b0;
                     flag_z_d       = 1'b0;
                     flag_n_d       = 1'b1;
                     flag_v_d       = 1'b1;
                     div_zero_d     = 1'b1;
                  end else begin
                     acc_hi_d    = '0;
                     acc_lo_d    = mag_a;
                     opnd_d      = mag_b;
                     is_div_d    = 1'b1;
                     is_signed_d = signed_op;
                     neg_res_d   = sign_a ^ sign_b;
                     neg_rem_d   = sign_a;
                     // MIN / -1: magnitude quotient already equals MIN.
                     ovf_d       = signed_op && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
                     cnt_d       = SHW'(WIDTH-1);
                     state_d     = S_ITER;
                  end
               end
            end
         end
         S_ITER: begin
            if (is_div_q) begin
               if (!div_try[WIDTH]) begin
                  acc_hi_d = div_try[WIDTH-1:0];
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_hi_d = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
                  acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
               end
            end else begin
               acc_hi_d = mul_sum[WIDTH:1];
               acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
            end
            if (cnt_q == '0) state_d = S_FIX;
            else             cnt_d   = cnt_q - 1'b1;
         end
         S_FIX: begin
            result_valid_d = 1'b1;
            div_zero_d     = 1'b0;
            if (is_div_q) begin
               result_lo_d = quo;
               result_hi_d = rem;
               flag_c_d    = 1'b0;
               flag_z_d    = (quo == '0);
               flag_n_d    = quo[WIDTH-1];
               flag_v_d    = ovf_q;
            end else begin
               result_lo_d = prod[WIDTH-1:0];
               result_hi_d = prod[2*WIDTH-1:WIDTH];
               flag_c_d    = (prod[2*WIDTH-1:WIDTH] != ext);
               flag_z_d    = (prod == '0);
               flag_n_d    = prod[2*WIDTH-1];
               flag_v_d    = (prod[2*WIDTH-1:WIDTH] != ext);
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         acc_hi_q       <= '0;
         acc_lo_q       <= '0;
         opnd_q         <= '0;
         is_div_q       <= 1'b0;
         is_signed_q    <= 1'b0;
         neg_res_q      <= 1'b0;
         neg_rem_q      <= 1'b0;
         ovf_q          <= 1'b0;
         result_valid_q <= 1'b0;
         result_lo_q    <= '0;
         result_hi_q    <= '0;
         flag_c_q       <= 1'b0;
         flag_z_q       <= 1'b0;
         flag_n_q       <= 1'b0;
         flag_v_q       <= 1'b0;
         div_zero_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         acc_hi_q       <= acc_hi_d;
         acc_lo_q       <= acc_lo_d;
         opnd_q         <= opnd_d;
         is_div_q       <= is_div_d;
         is_signed_q    <= is_signed_d;
         neg_res_q      <= neg_res_d;
         neg_rem_q      <= neg_rem_d;
         ovf_q          <= ovf_d;
         result_valid_q <= result_valid_d;
         result_lo_q    <= result_lo_d;
         result_hi_q    <= result_hi_d;
         flag_c_q       <= flag_c_d;
         flag_z_q       <= flag_z_d;
         flag_n_q       <= flag_n_d;
         flag_v_q       <= flag_v_d;
         div_zero_q     <= div_zero_d;
      end
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.result_valid = result_valid_q;
   assign bus.result_lo    = result_lo_q;
   assign bus.result_hi    = result_hi_q;
   assign bus.flag_c       = flag_c_q;
   assign bus.flag_z       = flag_z_q;
   assign bus.flag_n       = flag_n_q;
   assign bus.flag_v       = flag_v_q;
   assign bus.div_zero     = div_zero_q;
endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: directed vector table for single-cycle ops plus
// hand-written multiply/divide, stall and reset sequences.
module tb_execute_unit;
   localparam int W = 32;
   localparam logic [4:0] OP_NOP = 5'd0, OP_ADD = 5'd1, OP_ADC = 5'd2, OP_SUB = 5'd3;
   localparam logic [4:0] OP_SBB = 5'd4, OP_AND = 5'd5, OP_OR = 5'd6, OP_XOR = 5'd7;
   localparam logic [4:0] OP_NOT = 5'd8, OP_SHL = 5'd9, OP_SHR = 5'd10, OP_SAR = 5'd11;
   localparam logic [4:0] OP_ROL = 5'd12, OP_ROR = 5'd13, OP_RCL = 5'd14, OP_RCR = 5'd15;
   localparam logic [4:0] OP_UMUL = 5'd16, OP_SMUL = 5'd17, OP_UDIV = 5'd18, OP_SDIV = 5'd19;

   typedef struct {
      logic [4:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] lo;
      logic [3:0]   czvn;   // {c, z, n, v}
   } vec_t;

   localparam int NV = 24;
   vec_t vecs [NV];

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   failures = 0;

   execute_unit_if #(.WIDTH(W)) bus ();
   execute_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic issue(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
      bus.op        = op;
      bus.operand_a = a;
      bus.operand_b = b;
      bus.carry_in  = cin;
      bus.op_valid  = 1'b1;
      @(posedge clk); #1;
      bus.op_valid  = 1'b0;
   endtask

   // Called in the first cycle after acceptance; lat counts that cycle as 1.
   task automatic wait_result(output int lat, output int bcnt);
      lat  = 1;
      bcnt = 0;
      while (!bus.result_valid && lat < 200) begin
         if (bus.busy) bcnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_md(input string name, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat, input int exp_busy,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic [3:0] exp_f, input logic exp_dz);
      int lat, bcnt;
      issue(op, a, b, 1'b0);
      wait_result(lat, bcnt);
      chk({name, " latency"}, lat, exp_lat);
      chk({name, " busy_cycles"}, bcnt, exp_busy);
      chk({name, " busy_at_result"}, bus.busy, 1'b0);
      chk({name, " hi"}, bus.result_hi, exp_hi);
      chk({name, " lo"}, bus.result_lo, exp_lo);
      chk({name, " flags"}, {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v}, exp_f);
      chk({name, " div_zero"}, bus.div_zero, exp_dz);
   endtask

   initial begin
      int lat, bcnt, rv_seen;

      vecs[0]  = '{OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 4'b0011};
      vecs[1]  = '{OP_ADC, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 4'b1100};
      vecs[2]  = '{OP_SUB, 32'h00000005, 32'h00000005, 1'b0, 32'h00000000, 4'b0100};
      vecs[3]  = '{OP_SUB, 32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 4'b1010};
      vecs[4]  = '{OP_SBB, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 4'b1010};
      vecs[5]  = '{OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 4'b0001};
      vecs[6]  = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 32'h00F000F0, 4'b0000};
      vecs[7]  = '{OP_OR,  32'h00000F00, 32'h000000F0, 1'b1, 32'h00000FF0, 4'b0000};
      vecs[8]  = '{OP_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 4'b0100};
      vecs[9]  = '{OP_NOT, 32'h00000000, 32'h12345678, 1'b0, 32'hFFFFFFFF, 4'b0010};
      vecs[10] = '{OP_SHL, 32'h00000001, 32'h00000000, 1'b1, 32'h00000001, 4'b1000};
      vecs[11] = '{OP_SHL, 32'h80000001, 32'h00000001, 1'b0, 32'h00000002, 4'b1000};
      vecs[12] = '{OP_SHR, 32'h00000003, 32'h00000001, 1'b0, 32'h00000001, 4'b1000};
      vecs[13] = '{OP_SAR, 32'h80000000, 32'h00000004, 1'b0, 32'hF8000000, 4'b0010};
      vecs[14] = '{OP_ROL, 32'h80000001, 32'h00000001, 1'b0, 32'h00000003, 4'b1000};
      vecs[15] = '{OP_ROR, 32'h00000001, 32'h00000001, 1'b0, 32'h80000000, 4'b1010};
      vecs[16] = '{OP_RCL, 32'h80000000, 32'h00000001, 1'b0, 32'h00000000, 4'b1100};
      vecs[17] = '{OP_RCR, 32'h00000001, 32'h00000001, 1'b1, 32'h80000000, 4'b1010};
      vecs[18] = '{OP_SHR, 32'h00000004, 32'h00000021, 1'b0, 32'h00000002, 4'b0000};
      vecs[19] = '{OP_ADD, 32'h00000001, 32'h00000002, 1'b1, 32'h00000003, 4'b0000};
      vecs[20] = '{OP_SBB, 32'h00000005, 32'h00000003, 1'b1, 32'h00000001, 4'b0000};
      vecs[21] = '{OP_SAR, 32'h7FFFFFF0, 32'h00000000, 1'b0, 32'h7FFFFFF0, 4'b0000};
      vecs[22] = '{OP_ADD, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 4'b1101};
      vecs[23] = '{OP_ROR, 32'h00000010, 32'h0000001F, 1'b0, 32'h00000020, 4'b0000};

      bus.op_valid = 1'b0; bus.op = OP_NOP; bus.operand_a = '0; bus.operand_b = '0;
      bus.carry_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {bus.busy, bus.result_valid, bus.div_zero, bus.flag_c, bus.flag_z,
                            bus.flag_n, bus.flag_v, bus.result_hi, bus.result_lo}, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
         chk($sformatf("vec%0d valid", i), bus.result_valid, 1'b1);
         chk($sformatf("vec%0d lo", i), bus.result_lo, vecs[i].lo);
         chk($sformatf("vec%0d hi", i), bus.result_hi, '0);
         chk($sformatf("vec%0d flags", i), {bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v},
             vecs[i].czvn);
      end

      // NOP and an unused code: no pulse, results hold
      issue(OP_NOP, 32'h1, 32'h2, 1'b0);
      chk("nop valid", bus.result_valid, 1'b0);
      chk("nop hold lo", bus.result_lo, 32'h00000020);
      issue(5'd25, 32'h1, 32'h2, 1'b0);
      chk("code25 valid", bus.result_valid, 1'b0);
      chk("code25 busy", bus.busy, 1'b0);

      run_md("smul_neg", OP_SMUL, 32'hFFFFFFFE, 32'h3, 34, 33, 32'hFFFFFFFF, 32'hFFFFFFFA, 4'b0010, 1'b0);
      run_md("umul_max", OP_UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 33, 32'hFFFFFFFE, 32'h00000001, 4'b1011, 1'b0);
      run_md("smul_min", OP_SMUL, 32'h80000000, 32'h80000000, 34, 33, 32'h40000000, 32'h00000000, 4'b1001, 1'b0);
      run_md("umul_zero", OP_UMUL, 32'h0, 32'h1234, 34, 33, 32'h0, 32'h0, 4'b0100, 1'b0);
      run_md("sdiv_m7_2", OP_SDIV, 32'hFFFFFFF9, 32'h2, 34, 33, 32'hFFFFFFFF, 32'hFFFFFFFD, 4'b0010, 1'b0);
      run_md("udiv_100_7", OP_UDIV, 32'd100, 32'd7, 34, 33, 32'd2, 32'd14, 4'b0000, 1'b0);
      run_md("sdiv_min_m1", OP_SDIV, 32'h80000000, 32'hFFFFFFFF, 34, 33, 32'h0, 32'h80000000, 4'b0011, 1'b0);
      run_md("sdiv_7_m2", OP_SDIV, 32'd7, 32'hFFFFFFFE, 34, 33, 32'd1, 32'hFFFFFFFD, 4'b0010, 1'b0);
      run_md("udiv_by0", OP_UDIV, 32'h12345678, 32'h0, 1, 0, 32'h12345678, 32'hFFFFFFFF, 4'b0011, 1'b1);

      // div_zero holds between pulses, clears on the next result
      @(posedge clk); #1;
      chk("div_zero hold", bus.div_zero, 1'b1);
      issue(OP_ADD, 32'h1, 32'h1, 1'b0);
      chk("div_zero clear", bus.div_zero, 1'b0);
      chk("add after by0", bus.result_lo, 32'h2);

      // Controller holds an ADD on the bus while the divide is busy
      issue(OP_UDIV, 32'd100, 32'd7, 1'b0);
      bus.op = OP_ADD; bus.operand_a = 32'd10; bus.operand_b = 32'd20; bus.op_valid = 1'b1;
      wait_result(lat, bcnt);
      chk("stall udiv latency", lat, 34);
      chk("stall udiv lo", bus.result_lo, 32'd14);
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      chk("stall add valid", bus.result_valid, 1'b1);
      chk("stall add lo", bus.result_lo, 32'd30);
      chk("stall add hi", bus.result_hi, 32'd0);
      @(posedge clk); #1;
      chk("stall add once", bus.result_valid, 1'b0);

      // Reset in the middle of a multiply
      issue(OP_UMUL, 32'd3, 32'd5, 1'b0);
      repeat (9) @(posedge clk);
      #1;
      chk("pre_reset busy", bus.busy, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midmul reset outputs", {bus.busy, bus.result_valid, bus.div_zero, bus.flag_c, bus.flag_z,
                                   bus.flag_n, bus.flag_v, bus.result_hi, bus.result_lo}, '0);
      rv_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.result_valid || bus.busy) rv_seen++;
      end
      chk("midmul discarded", rv_seen, 0);
      issue(OP_ADD, 32'd2, 32'd3, 1'b0);
      chk("post_reset add valid", bus.result_valid, 1'b1);
      chk("post_reset add lo", bus.result_lo, 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
